// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative HI/LO multiply/divide sequencer with pipeline stall request
// Optional early multiply termination: define MULDIV_EARLY_TERM_EN.
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    // acc holds the running upper product half or the partial remainder
    logic [WIDTH:0]   acc_q, acc_d;
    // q holds the multiplier/low product bits or the dividend/quotient bits
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             is_div_q, is_div_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
`ifdef MULDIV_EARLY_TERM_EN
    logic [WIDTH-1:0] mrem_q, mrem_d;
`endif

    logic             signed_op, is_div_op, a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             borrow;
    logic             last_iter;
    logic [2*WIDTH-1:0] raw_prod, fix_prod;
    logic [WIDTH-1:0] fix_quot, fix_rem;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        is_div_op = (op == OP_DIV) || (op == OP_DIVU);
        a_neg     = signed_op & rs_val[WIDTH-1];
        b_neg     = signed_op & rt_val[WIDTH-1];
        abs_a     = a_neg ? -rs_val : rs_val;
        abs_b     = b_neg ? -rt_val : rt_val;

        mul_sum   = acc_q + (q_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        borrow    = div_diff[WIDTH+1];
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_TERM_EN
        // an early-terminated product still sits left-aligned by the skipped iterations
        raw_prod = {acc_q[WIDTH-1:0], q_q} >> (CNT_W'(WIDTH) - cnt_q);
`else
        raw_prod = {acc_q[WIDTH-1:0], q_q};
`endif
        fix_prod = qneg_q ? -raw_prod : raw_prod;
        fix_quot = qneg_q ? -q_q : q_q;
        fix_rem  = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        q_d      = q_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
        mrem_d   = mrem_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            if (is_div_op && (rt_val == '0)) begin
                                dz_d = 1'b1;
                            end else begin
                                state_d  = S_CALC;
                                cnt_d    = '0;
                                acc_d    = '0;
                                is_div_d = is_div_op;
                                qneg_d   = a_neg ^ b_neg;
                                rneg_d   = a_neg;
                                q_d      = is_div_op ? abs_a : abs_b;
                                opb_d    = is_div_op ? abs_b : abs_a;
`ifdef MULDIV_EARLY_TERM_EN
                                mrem_d   = abs_b;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_div_q) begin
                        acc_d = borrow ? div_shift : div_diff[WIDTH:0];
                        q_d   = {q_q[WIDTH-2:0], ~borrow};
                    end else begin
                        acc_d = {1'b0, mul_sum[WIDTH:1]};
                        q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
                    end
`ifdef MULDIV_EARLY_TERM_EN
                    mrem_d = mrem_q >> 1;
                    if (last_iter || (!is_div_q && (mrem_d == '0)))
                        state_d = S_FIX;
`else
                    if (last_iter)
                        state_d = S_FIX;
`endif
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = fix_rem;
                        lo_d = fix_quot;
                    end else begin
                        hi_d = fix_prod[2*WIDTH-1:WIDTH];
                        lo_d = fix_prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
            mrem_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
`ifdef MULDIV_EARLY_TERM_EN
            mrem_q   <= mrem_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign stall_req = (busy & (hilo_rd | start)) | ((state_q == S_FIX) & hilo_rd);
    assign done      = done_q;
    assign dz        = dz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule
